// File: rtl/stage2_flatten_buffer.sv
`default_nettype none
// ============================================================================
// Module   : stage2_flatten_buffer
// Purpose  : ReLU + round-half-up requantization of the pooled stage-2 stream,
//            captured into a two-bank (ping-pong) flatten buffer and streamed
//            to the FC stage over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module stage2_flatten_buffer #(
  parameter  int IBW    = 19,
  parameter  int OBW    = 8,
  parameter  int POOL_X = 12,
  parameter  int POOL_Y = 12,
  parameter  int SHIFT  = 8,
  localparam int N      = POOL_X * POOL_Y,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_in_valid,
  input  logic [IBW-1:0] i_in_fmap,
  output logic           o_ot_valid,
  input  logic           i_ot_ready,
  output logic [OBW-1:0] o_ot_data,
  output logic [IW-1:0]  o_ot_idx,
  output logic           o_ot_last,
  output logic           o_overflow
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  // Rounding constant 2^(SHIFT-1) and the saturation ceiling 2^OBW-1.
  localparam logic [IBW:0]  RND      = (IBW + 1)'(1) << (SHIFT - 1);
  localparam logic [IBW:0]  QMAX     = (IBW + 1)'((1 << OBW) - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state;
  logic [OBW-1:0] mem [2][N];
  logic [1:0]     full;
  logic           wr_bank;
  logic [IW-1:0]  wr_idx;
  logic           rd_bank;

  logic [IBW:0]   rnd_sum;
  logic [IBW:0]   q_full;
  logic [OBW-1:0] q_sat;
  logic           wr_accept;
  logic           wr_wrap;
  logic           rd_wrap;
  logic [IW-1:0]  next_idx;

  // Quantize the incoming point: negatives clamp to zero, positives are
  // rounded half-up by SHIFT bits and saturated to the output range.
  always_comb begin
    rnd_sum = {1'b0, i_in_fmap} + RND;
    q_full  = rnd_sum >> SHIFT;
    q_sat   = '0;
    if (i_in_fmap[IBW-1]) begin
      q_sat = '0;
    end else if (q_full > QMAX) begin
      q_sat = '1;
    end else begin
      q_sat = q_full[OBW-1:0];
    end
  end

  // Handshake qualifiers; the write decision looks only at pre-edge flags,
  // so a bank being freed on this same edge does not take this sample.
  always_comb begin
    wr_accept = i_in_valid && !full[wr_bank];
    wr_wrap   = wr_accept && (wr_idx == LAST_IDX);
    rd_wrap   = (state == SEND) && o_ot_valid && i_ot_ready && (o_ot_idx == LAST_IDX);
    next_idx  = o_ot_idx + 1'b1;
  end

  // Buffer storage: only the requantized OBW-bit values are kept.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_bank][wr_idx] <= q_sat;
    end
  end

  // Write pointer and sticky drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_in_valid && full[wr_bank]) begin
        o_overflow <= 1'b1;
      end
      if (wr_accept) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end

  // Bank-full flags: set by a completed write frame, cleared by a drained
  // read frame. The two events can only target different banks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_wrap && (wr_bank == 1'(b))) begin
          full[b] <= 1'b1;
        end else if (rd_wrap && (rd_bank == 1'(b))) begin
          full[b] <= 1'b0;
        end
      end
    end
  end

  // Read FSM: waits for a full bank, then streams its elements in order
  // with registered data/idx/last held steady while the sink stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_bank    <= 1'b0;
      o_ot_valid <= 1'b0;
      o_ot_data  <= '0;
      o_ot_idx   <= '0;
      o_ot_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            o_ot_data  <= mem[rd_bank][0];
            o_ot_idx   <= '0;
            o_ot_last  <= 1'(N == 1);
            o_ot_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (o_ot_valid && i_ot_ready) begin
            if (o_ot_idx == LAST_IDX) begin
              o_ot_valid <= 1'b0;
              o_ot_last  <= 1'b0;
              rd_bank    <= ~rd_bank;
              state      <= IDLE;
            end else begin
              o_ot_data <= mem[rd_bank][next_idx];
              o_ot_idx  <= next_idx;
              o_ot_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage2_flatten_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage2_flatten_buffer
// Purpose  : Self-checking bench for stage2_flatten_buffer. A frame-level
//            model (expected-element queue plus a count of buffered frames)
//            predicts every output beat and every dropped sample.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage2_flatten_buffer;

  localparam int IBW    = 19;
  localparam int OBW    = 8;
  localparam int POOL_X = 12;
  localparam int POOL_Y = 12;
  localparam int SHIFT  = 8;
  localparam int N      = POOL_X * POOL_Y;
  localparam int IW     = $clog2(N);

  logic           clk = 1'b0;
  logic           reset_n;
  logic           i_in_valid;
  logic [IBW-1:0] i_in_fmap;
  logic           o_ot_valid;
  logic           i_ot_ready = 1'b0;
  logic [OBW-1:0] o_ot_data;
  logic [IW-1:0]  o_ot_idx;
  logic           o_ot_last;
  logic           o_overflow;

  stage2_flatten_buffer #(
    .IBW(IBW), .OBW(OBW), .POOL_X(POOL_X), .POOL_Y(POOL_Y), .SHIFT(SHIFT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (i_in_valid),
    .i_in_fmap  (i_in_fmap),
    .o_ot_valid (o_ot_valid),
    .i_ot_ready (i_ot_ready),
    .o_ot_data  (o_ot_data),
    .o_ot_idx   (o_ot_idx),
    .o_ot_last  (o_ot_last),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  // Model state
  int checks     = 0;
  int failures   = 0;
  int exp_q[$];          // expected output elements, in order
  int pending    = 0;    // completed frames not yet fully drained
  int wr_count   = 0;    // accepted samples of the frame being filled
  int beat_idx   = 0;    // expected index of the current output element
  int beats_seen = 0;
  int ready_mode = 0;    // 0: ready low, 1: ready high, 2: random 30%
  logic ovf_exp  = 1'b0;

  logic           prev_stall   = 1'b0;
  logic           prev_last_hs = 1'b0;
  logic [OBW-1:0] prev_data;
  logic [IW-1:0]  prev_idx;
  logic           prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantization written from the arithmetic definition.
  function automatic int quant(input logic [IBW-1:0] v);
    int q;
    if (v[IBW-1]) return 0;
    q = (int'(v) + 2 ** (SHIFT - 1)) / (2 ** SHIFT);
    return (q > 2 ** OBW - 1) ? 2 ** OBW - 1 : q;
  endfunction

  // Ready driver, updated shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       i_ot_ready = 1'b0;
      1:       i_ot_ready = 1'b1;
      default: i_ot_ready = ($urandom_range(0, 99) < 30);
    endcase
  end

  // Output monitor on the falling edge: stability under stall, bubble after
  // each frame, and every presented element against the model queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
      beat_idx     = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", 32'(o_ot_data), 32'(prev_data));
        chk("hold_idx",  32'(o_ot_idx),  32'(prev_idx));
        chk("hold_last", 32'(o_ot_last), 32'(prev_last));
      end
      if (prev_last_hs) begin
        chk("bubble_valid", 32'(o_ot_valid), 32'(0));
      end
      if (o_ot_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(o_ot_valid), 32'(0));
        end else begin
          chk("data", 32'(o_ot_data), 32'(exp_q[0]));
          chk("idx",  32'(o_ot_idx),  32'(beat_idx));
          chk("last", 32'(o_ot_last), 32'(beat_idx == N - 1));
        end
      end
      prev_stall   = o_ot_valid && !i_ot_ready;
      prev_data    = o_ot_data;
      prev_idx     = o_ot_idx;
      prev_last    = o_ot_last;
      prev_last_hs = o_ot_valid && i_ot_ready && (beat_idx == N - 1);
      if (o_ot_valid && i_ot_ready) begin
        beats_seen++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (beat_idx == N - 1) begin
          beat_idx = 0;
          pending--;
        end else begin
          beat_idx++;
        end
      end
    end
  end

  // Present one sample for one cycle. e < 0 means "use the model value".
  task automatic drive(input logic [IBW-1:0] v, input int e);
    i_in_valid = 1'b1;
    i_in_fmap  = v;
    if (pending == 2) begin
      ovf_exp = 1'b1;
    end else begin
      exp_q.push_back((e < 0) ? quant(v) : e);
      wr_count++;
      if (wr_count == N) begin
        wr_count = 0;
        pending++;
      end
    end
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    chk("overflow", 32'(o_overflow), 32'(ovf_exp));
  endtask

  task automatic send_random_frame();
    for (int k = 0; k < N; k++) drive(IBW'($urandom), -1);
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while ((exp_q.size() != 0 || o_ot_valid) && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_ot_valid), 32'(0));
    chk({tag, "_data"},  32'(o_ot_data),  32'(0));
    chk({tag, "_idx"},   32'(o_ot_idx),   32'(0));
    chk({tag, "_last"},  32'(o_ot_last),  32'(0));
    chk({tag, "_ovf"},   32'(o_overflow), 32'(0));
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero(tag);
    exp_q.delete();
    pending  = 0;
    wr_count = 0;
    ovf_exp  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [IBW-1:0] corner_in  [8];
  int             corner_exp [8];
  int             base;
  int             budget;

  initial begin
    reset_n    = 1'b0;
    i_in_valid = 1'b0;
    i_in_fmap  = '0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single frame of ramp values k*256, continuous ready, with latency check.
    ready_mode = 1;
    for (int k = 0; k < N; k++) drive(IBW'(k * 256), k);
    chk("lat_valid_before", 32'(o_ot_valid), 32'(0));
    @(posedge clk); #1;
    chk("lat_valid_after", 32'(o_ot_valid), 32'(1));
    chk("lat_idx_first",   32'(o_ot_idx),   32'(0));
    wait_drain(400);

    // Quantization corners at the head of a frame, random remainder.
    corner_in[0] = 19'h3FFFF; corner_exp[0] = 255;
    corner_in[1] = 19'h40000; corner_exp[1] = 0;
    corner_in[2] = 19'h7FFFF; corner_exp[2] = 0;
    corner_in[3] = 19'h00080; corner_exp[3] = 1;
    corner_in[4] = 19'h0007F; corner_exp[4] = 0;
    corner_in[5] = 19'h0FF7F; corner_exp[5] = 255;
    corner_in[6] = 19'h0FE80; corner_exp[6] = 255;
    corner_in[7] = 19'h0FE7F; corner_exp[7] = 254;
    for (int k = 0; k < 8; k++) drive(corner_in[k], corner_exp[k]);
    for (int k = 8; k < N; k++) drive(IBW'($urandom), -1);
    wait_drain(400);

    // Overlap: frame B streams in while frame A drains.
    send_random_frame();
    send_random_frame();
    wait_drain(400);

    // Backpressure: random ready at roughly 30% duty.
    ready_mode = 2;
    send_random_frame();
    send_random_frame();
    wait_drain(3000);

    // Ping-pong: both banks fill under stall, the next sample is dropped.
    ready_mode = 0;
    send_random_frame();
    send_random_frame();
    repeat (2) begin @(posedge clk); #1; end
    chk("pp_valid", 32'(o_ot_valid), 32'(1));
    chk("pp_idx",   32'(o_ot_idx),   32'(0));
    drive(IBW'($urandom), -1);
    ready_mode = 1;
    wait_drain(600);
    chk("pp_ovf_sticky", 32'(o_overflow), 32'(1));

    // Reset after 70 inputs of a partial frame.
    for (int k = 0; k < 70; k++) drive(IBW'($urandom), -1);
    async_reset("rst_partial");

    // Reset after 50 output beats of a draining frame.
    send_random_frame();
    base   = beats_seen;
    budget = 400;
    while (beats_seen < base + 50 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("rst_beats_reached", 32'(beats_seen >= base + 50), 32'(1));
    async_reset("rst_draining");

    // A fresh frame after reset must start at index 0 and complete.
    send_random_frame();
    wait_drain(400);
    chk("final_ovf", 32'(o_overflow), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
